// File: rtl/pll_lock_supervisor_pkg.sv
// Shared state encoding and counter-width helper for the PLL lock supervisor.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4,
    StFail     = 3'd5
  } state_e;

  // Width of a counter that must be able to hold max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, cleared by async active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor with ordered domain release and lock-loss re-sequencing.
// Optional saturating lock-loss event counter enabled by LOCK_LOSS_COUNTER_EN.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int unsigned NUM_PLL             = 1,
  parameter int unsigned NUM_DOMAINS         = 4,
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 200000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned RELEASE_GAP_CYCLES  = 64,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_PLL-1:0]                 i_locked,
  input  logic                               i_force_restart,
  output logic                               o_pll_reset,
  output logic [NUM_DOMAINS-1:0]             o_domain_rst_n,
  output logic                               o_all_ready,
  output logic                               o_fail,
  output logic [cnt_w(MAX_RETRIES)-1:0]      o_retry_count,
  output logic [15:0]                        o_lock_loss_count
);

  localparam int unsigned PulseW   = cnt_w(RST_PULSE_CYCLES);
  localparam int unsigned TimeoutW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int unsigned StableW  = cnt_w(LOCK_STABLE_CYCLES);
  localparam int unsigned GapW     = cnt_w(RELEASE_GAP_CYCLES);
  localparam int unsigned IdxW     = cnt_w(NUM_DOMAINS);
  localparam int unsigned RetryW   = cnt_w(MAX_RETRIES);

  localparam logic [PulseW-1:0]   PulseLast   = PulseW'(RST_PULSE_CYCLES - 1);
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [StableW-1:0]  StableLast  = StableW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GapW-1:0]     GapLast     = GapW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [IdxW-1:0]     IdxLast     = IdxW'(NUM_DOMAINS - 1);
  localparam logic [RetryW-1:0]   RetryMax    = RetryW'(MAX_RETRIES);

  logic [NUM_PLL-1:0] w_locked_sync;
  logic               w_locked_all;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_sync
    sync_2ff u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_locked[g]),
      .o_q     (w_locked_sync[g])
    );
  end

  assign w_locked_all = &w_locked_sync;

  state_e                   r_state,   w_state_d;
  logic [PulseW-1:0]        r_pulse,   w_pulse_d;
  logic [TimeoutW-1:0]      r_timeout, w_timeout_d;
  logic [StableW-1:0]       r_stable,  w_stable_d;
  logic [GapW-1:0]          r_gap,     w_gap_d;
  logic [IdxW-1:0]          r_idx,     w_idx_d;
  logic [RetryW-1:0]        r_retry,   w_retry_d;
  logic                     r_pll_reset, w_pll_reset_d;
  logic [NUM_DOMAINS-1:0]   r_dom_rst_n, w_dom_rst_n_d;
  logic                     r_all_ready, w_all_ready_d;
  logic                     r_fail,      w_fail_d;
  logic                     w_loss_evt;

  // Counters default to zero so any state change or restart clears them.
  always_comb begin
    w_state_d   = r_state;
    w_pulse_d   = '0;
    w_timeout_d = '0;
    w_stable_d  = '0;
    w_gap_d     = '0;
    w_idx_d     = '0;
    w_retry_d   = r_retry;
    w_loss_evt  = 1'b0;

    if (i_force_restart) begin
      w_state_d = StResetPll;
      w_retry_d = '0;
    end else begin
      unique case (r_state)
        StResetPll: begin
          if (r_pulse == PulseLast) w_state_d = StWaitLock;
          else                      w_pulse_d = r_pulse + 1'b1;
        end
        StWaitLock: begin
          if (w_locked_all) begin
            w_state_d = StStable;
          end else if (r_timeout == TimeoutLast) begin
            if (r_retry < RetryMax) begin
              w_retry_d = r_retry + 1'b1;
              w_state_d = StResetPll;
            end else begin
              w_state_d = StFail;
            end
          end else begin
            w_timeout_d = r_timeout + 1'b1;
          end
        end
        StStable: begin
          if (!w_locked_all) begin
            w_state_d = StWaitLock;
          end else if (r_stable == StableLast) begin
            w_state_d = StRelease;
            w_retry_d = '0;
          end else begin
            w_stable_d = r_stable + 1'b1;
          end
        end
        StRelease: begin
          if (!w_locked_all) begin
            w_state_d  = StResetPll;
            w_retry_d  = '0;
            w_loss_evt = 1'b1;
          end else if (r_idx == IdxLast) begin
            w_state_d = StRun;
          end else if (r_gap == GapLast) begin
            w_idx_d = r_idx + 1'b1;
          end else begin
            w_gap_d = r_gap + 1'b1;
            w_idx_d = r_idx;
          end
        end
        StRun: begin
          if (!w_locked_all) begin
            w_state_d  = StResetPll;
            w_retry_d  = '0;
            w_loss_evt = 1'b1;
          end
        end
        StFail: begin
          w_state_d = StFail;
        end
        default: w_state_d = StResetPll;
      endcase
    end

    // Outputs follow the next state so they appear on the entry cycle.
    w_pll_reset_d = (w_state_d == StResetPll) || (w_state_d == StFail);
    w_all_ready_d = (w_state_d == StRun);
    w_fail_d      = (w_state_d == StFail);
    w_dom_rst_n_d = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if ((w_state_d == StRun) || ((w_state_d == StRelease) && (IdxW'(i) <= w_idx_d))) begin
        w_dom_rst_n_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StResetPll;
      r_pulse     <= '0;
      r_timeout   <= '0;
      r_stable    <= '0;
      r_gap       <= '0;
      r_idx       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_dom_rst_n <= '0;
      r_all_ready <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pulse     <= w_pulse_d;
      r_timeout   <= w_timeout_d;
      r_stable    <= w_stable_d;
      r_gap       <= w_gap_d;
      r_idx       <= w_idx_d;
      r_retry     <= w_retry_d;
      r_pll_reset <= w_pll_reset_d;
      r_dom_rst_n <= w_dom_rst_n_d;
      r_all_ready <= w_all_ready_d;
      r_fail      <= w_fail_d;
    end
  end

  assign o_pll_reset    = r_pll_reset;
  assign o_domain_rst_n = r_dom_rst_n;
  assign o_all_ready    = r_all_ready;
  assign o_fail         = r_fail;
  assign o_retry_count  = r_retry;

`ifdef LOCK_LOSS_COUNTER_EN
  logic [15:0] r_loss_cnt;

  // Survives force-restart; only the hard reset clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != 16'hFFFF)) begin
      r_loss_cnt <= r_loss_cnt + 16'd1;
    end
  end

  assign o_lock_loss_count = r_loss_cnt;
`else
  logic w_unused_loss_evt;
  assign w_unused_loss_evt = w_loss_evt;
  assign o_lock_loss_count = 16'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: tests push per-cycle expected outputs,
// a monitor pops one entry per clock and compares it against the DUT.
module tb_pll_lock_supervisor;

`ifdef LOCK_LOSS_COUNTER_EN
  localparam int LossStep = 1;
`else
  localparam int LossStep = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  locked = 2'b00;
  logic        force_restart = 1'b0;
  logic        pll_reset;
  logic [3:0]  dom;
  logic        all_ready;
  logic        fail;
  logic [1:0]  retry;
  logic [15:0] loss;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_PLL             (2),
    .NUM_DOMAINS         (4),
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (50),
    .LOCK_STABLE_CYCLES  (8),
    .RELEASE_GAP_CYCLES  (3),
    .MAX_RETRIES         (2)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_locked          (locked),
    .i_force_restart   (force_restart),
    .o_pll_reset       (pll_reset),
    .o_domain_rst_n    (dom),
    .o_all_ready       (all_ready),
    .o_fail            (fail),
    .o_retry_count     (retry),
    .o_lock_loss_count (loss)
  );

  typedef struct packed {
    logic       pll;
    logic [3:0] dom;
    logic       rdy;
    logic       fail;
    logic [1:0] retry;
  } exp_t;

  exp_t  sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string tname = "none";

  task automatic sb_push(input int n, input logic pll, input logic [3:0] d, input logic rdy,
                         input logic f, input logic [1:0] r);
    exp_t e;
    e = {pll, d, rdy, f, r};
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic drain();
    wait (sb_q.size() == 0);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = {pll_reset, dom, all_ready, fail, retry};
      checks++;
      cyc++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s entry %0d: got pll=%b dom=%b rdy=%b fail=%b retry=%0d, want pll=%b dom=%b rdy=%b fail=%b retry=%0d",
                 tname, cyc, a.pll, a.dom, a.rdy, a.fail, a.retry,
                 e.pll, e.dom, e.rdy, e.fail, e.retry);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    locked = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tname = "reset"; cyc = 0;
    rst_n = 1'b0; locked = 2'b00; force_restart = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pll_reset, dom, all_ready, fail, retry} !== 9'b1_0000_0_0_00) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want %b", {pll_reset, dom, all_ready, fail, retry},
               9'b1_0000_0_0_00);
    end
    checks++;
    if (loss !== 16'd0) begin
      errors++;
      $display("FAIL reset_loss_count: got %0d, want 0", loss);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    tname = "nominal"; cyc = 0;
    sb_push(3, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(11, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain();
    locked = 2'b11;
    sb_push(10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0111, 1'b0, 1'b0, 2'd0);
    sb_push(1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    drain();
  endtask

  task automatic test_lock_loss_in_run();
    tname = "lock_loss_run"; cyc = 0;
    locked = 2'b10;
    sb_push(2, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    sb_push(4, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain();
    locked = 2'b11;
    sb_push(10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0111, 1'b0, 1'b0, 2'd0);
    sb_push(1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    sb_push(2, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    drain();
    checks++;
    if (loss !== 16'(LossStep)) begin
      errors++;
      $display("FAIL loss_count_after_loss: got %0d, want %0d", loss, LossStep);
    end
  endtask

  task automatic test_lock_never();
    tname = "lock_never"; cyc = 0;
    locked = 2'b00;
    sb_push(2, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    sb_push(4, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(50, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(4, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1);
    sb_push(50, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1);
    sb_push(4, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2);
    sb_push(50, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2);
    sb_push(5, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
    drain();
    checks++;
    if (loss !== 16'(2 * LossStep)) begin
      errors++;
      $display("FAIL loss_count_in_fail: got %0d, want %0d", loss, 2 * LossStep);
    end
  endtask

  task automatic test_force_restart();
    tname = "force_restart"; cyc = 0;
    sb_push(4, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    force_restart = 1'b1;
    @(posedge clk);
    #2;
    force_restart = 1'b0;
    drain();
    checks++;
    if (loss !== 16'(2 * LossStep)) begin
      errors++;
      $display("FAIL loss_count_after_restart: got %0d, want %0d", loss, 2 * LossStep);
    end
  endtask

  task automatic test_glitch_in_stable();
    tname = "glitch_stable"; cyc = 0;
    do_reset();
    sb_push(3, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(11, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain();
    locked = 2'b11;
    sb_push(5, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain();
    locked = 2'b01;
    sb_push(1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain();
    locked = 2'b11;
    sb_push(10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0111, 1'b0, 1'b0, 2'd0);
    sb_push(1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    sb_push(2, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    drain();
  endtask

  task automatic test_async_reset_release();
    tname = "async_reset"; cyc = 0;
    do_reset();
    sb_push(3, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(11, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    drain();
    locked = 2'b11;
    sb_push(10, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    sb_push(2, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_reset, dom, all_ready, fail, retry} !== 9'b1_0000_0_0_00) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b, want %b",
               {pll_reset, dom, all_ready, fail, retry}, 9'b1_0000_0_0_00);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_push(3, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(9, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0);
    sb_push(3, 1'b0, 4'b0111, 1'b0, 1'b0, 2'd0);
    sb_push(1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0);
    sb_push(2, 1'b0, 4'b1111, 1'b1, 1'b0, 2'd0);
    drain();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss_in_run();
    test_lock_never();
    test_force_restart();
    test_glitch_in_stable();
    test_async_reset_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises one or more PLLs running off the board reference clock.
- Drives PLL reset with a guaranteed minimum pulse, then waits for lock with a timeout and bounded retries.
- Debounces lock, then releases per-domain reset requests in a fixed order with a programmable gap.
- Detects lock loss at any time and re-sequences. Sits between the clock-generation wrapper and the controller/PHY reset synchronisers.
- Runs entirely in the reference clock domain.

Parameters:
- NUM_PLL, 1, number of PLL locked inputs; all must be locked.
- NUM_DOMAINS, 4, number of ordered domain reset outputs.
- RST_PULSE_CYCLES, 16, PLL reset pulse width in i_clk cycles; minimum 1.
- LOCK_TIMEOUT_CYCLES, 200000, maximum cycles in WAIT_LOCK before a retry.
- LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before release.
- RELEASE_GAP_CYCLES, 64, cycles between successive domain releases; minimum 1.
- MAX_RETRIES, 3, timeout retries allowed before FAIL.

Ports:
- i_clk, input, 1, reference clock; all logic runs on its rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_locked, input, NUM_PLL, PLL locked flags; asynchronous, synchronised internally.
- i_force_restart, input, 1, synchronous restart request, single-cycle pulse.
- o_pll_reset, output, 1, active-high reset to all PLLs.
- o_domain_rst_n, output, NUM_DOMAINS, per-domain reset requests, active-low.
- o_all_ready, output, 1, high when every domain is released and the FSM is in RUN.
- o_fail, output, 1, high while in the FAIL state.
- o_retry_count, output, $clog2(MAX_RETRIES+1), current retry count.
- o_lock_loss_count, output, 16, lock-loss event counter (see Optional Feature).

Behaviour:
- Reset (i_rst_n low), applied asynchronously:
  - state=RESET_PLL, o_pll_reset=1, o_domain_rst_n=0, o_all_ready=0, o_fail=0.
  - Retry count, all timers and the synchroniser flops are cleared to 0.
- Lock synchronisation: each i_locked bit passes through a 2-flop synchroniser. locked_all is the AND of the synchronised bits. An i_locked edge becomes visible to the FSM 2 cycles later.
- All outputs are registered; a state's outputs appear on the cycle the state is entered.
- RESET_PLL: o_pll_reset=1 and all domains held in reset. After exactly RST_PULSE_CYCLES cycles in this state, go to WAIT_LOCK; o_pll_reset=0 from that cycle.
- WAIT_LOCK: the timeout timer counts from 0.
  - locked_all=1 → go to STABLE with the stable counter at 0.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 without lock:
    - retry<MAX_RETRIES → retry+1, go to RESET_PLL.
    - otherwise → go to FAIL.
- STABLE: the stable counter increments on each cycle with locked_all=1.
  - locked_all=0 → return to WAIT_LOCK; timeout timer restarts, retry count unchanged, no PLL reset pulse.
  - Counter reaches LOCK_STABLE_CYCLES-1 → go to RELEASE and clear the retry count.
- RELEASE: domains are released in ascending index order.
  - Domain 0 is released on the entry cycle.
  - Domain k is released RELEASE_GAP_CYCLES after domain k-1.
  - The cycle after the last domain is released: go to RUN, o_all_ready=1.
- RUN: hold all outputs steady.
- Lock loss (locked_all=0 in RELEASE or RUN), at the next edge:
  - o_domain_rst_n=0 and o_all_ready=0.
  - Go to RESET_PLL with retry count 0; a lock-loss event is counted.
  - Domain resets therefore assert on the 3rd i_clk edge after i_locked falls.
- FAIL: o_fail=1, o_pll_reset=1, all domains held in reset. Exit only via i_rst_n or i_force_restart.
- i_force_restart=1 in any state → go to RESET_PLL; retry=0, domains reset, o_fail=0, all timers cleared. Priority: i_rst_n > i_force_restart > lock loss > timer events.
- Counter widths are $clog2(max+1) of their respective limits. No counter wraps; each is cleared on every state change.

Optional Feature:
- Macro: LOCK_LOSS_COUNTER_EN.
- Defined:
  - o_lock_loss_count is a 16-bit counter, saturating at 16'hFFFF.
  - Increments once per lock-loss event in RELEASE or RUN.
  - Cleared only by i_rst_n; not cleared by i_force_restart.
- Not defined: o_lock_loss_count is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package/include holds:
  - State encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5, with 3-bit state width.
  - The counter-width helper constant.
- One sub-module: sync_2ff, a per-bit 2-flop synchroniser with async active-low clear, instantiated NUM_PLL times.

Test Plan:
Bench parameters unless stated: NUM_PLL=2, NUM_DOMAINS=4, RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=8, RELEASE_GAP_CYCLES=3, MAX_RETRIES=2.
- Nominal bring-up:
  - Stimulus: both locked rise 10 cycles after o_pll_reset falls.
  - Response: o_pll_reset high for exactly 4 cycles. o_domain_rst_n steps 0001→0011→0111→1111 at 3-cycle spacing, starting 2+8 cycles after lock. o_all_ready=1 one cycle after 1111.
- Lock never asserts:
  - Stimulus: locked held low.
  - Response: three o_pll_reset pulses of 4 cycles, each separated by 50 cycles. Then o_fail=1, o_retry_count=2, o_pll_reset stays 1, domains stay 0.
- Glitch in STABLE:
  - Stimulus: locked[1] low for 1 cycle after 5 stable cycles.
  - Response: no PLL reset pulse, stable count restarts, release delayed by 6 cycles versus nominal, retry count unchanged.
- Lock loss in RUN:
  - Stimulus: locked[0] falls.
  - Response: on the 3rd edge o_domain_rst_n=0000 and o_all_ready=0. Then a 4-cycle o_pll_reset pulse and full re-sequence. With LOCK_LOSS_COUNTER_EN, o_lock_loss_count=1.
- Force restart from FAIL:
  - Stimulus: 1-cycle i_force_restart pulse.
  - Response: next cycle o_fail=0, o_retry_count=0, new 4-cycle pulse. o_lock_loss_count is preserved.
- Async reset mid-RELEASE:
  - Stimulus: i_rst_n driven low while o_domain_rst_n=0011, between clock edges.
  - Response: o_domain_rst_n=0000 and o_pll_reset=1 immediately, without waiting for an edge; the sequence restarts after i_rst_n rises.
